// File: rtl/pipeline_run_ctrl_if.sv
// Host command channel for the pipeline run controller: valid/ready handshake
// carrying a 2-bit command (00 NOP, 01 RUN, 10 STEP, 11 PAUSE).
interface pipeline_run_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline with HALT drain and a saturating cycle counter.
// Optional watchdog enabled by defining PIPE_WATCHDOG_EN.
//
// state | meaning
// IDLE  | pipeline frozen, waiting for RUN or STEP
// RUN   | free running until HALT, PAUSE or watchdog
// STEP  | one enabled cycle, then back to IDLE
// DRAIN | HALT seen, retiring older instructions for DRAIN_CYCLES cycles
// DONE  | frozen, halted; left only through reset
module pipeline_run_ctrl #(
  parameter int          B            = 32,
  parameter int          CW           = 32,
  parameter logic [5:0]  HALT_OPCODE  = 6'h3F,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          WDOG_LIMIT   = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_run_ctrl_if.slave   cmd,
  input  logic [B-1:0]         instruction_IF_ID,
  output logic                 pipe_en,
  output logic [2:0]           state_o,
  output logic [CW-1:0]        cycle_count,
  output logic                 done,
  output logic                 halted,
  output logic                 timeout
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  state_t        state_q, state_d;
  logic [3:0]    drain_q, drain_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          accept, hit, wdog_hit;

  assign pipe_en   = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign cmd.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign hit       = pipe_en && (instruction_IF_ID[B-1:B-6] == HALT_OPCODE);

`ifdef PIPE_WATCHDOG_EN
  assign wdog_hit  = (state_q == ST_RUN) && (cycle_q == CW'(WDOG_LIMIT - 1));
`else
  assign wdog_hit  = 1'b0;
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
`endif

  logic unused_instr;
  assign unused_instr = ^instruction_IF_ID[B-7:0];

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    cycle_d   = cycle_q;

    // saturate instead of wrapping so the debug side never sees a small count after a long run
    if (pipe_en && (cycle_q != {CW{1'b1}}))
      cycle_d = cycle_q + CW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (accept && cmd.cmd_code == CMD_RUN)       state_d = ST_RUN;
        else if (accept && cmd.cmd_code == CMD_STEP) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (hit) begin
          state_d = ST_DRAIN;
          drain_d = 4'(DRAIN_CYCLES);
        end else if (wdog_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else if (accept && cmd.cmd_code == CMD_PAUSE) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (hit) begin
          state_d = ST_DRAIN;
          drain_d = 4'(DRAIN_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 4'd1;
        if (drain_q == 4'd1) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      drain_q   <= 4'd0;
      cycle_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign state_o     = state_q;
  assign cycle_count = cycle_q;
  assign done        = done_q;
  assign halted      = (state_q == ST_DONE);
`ifdef PIPE_WATCHDOG_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed self-checking bench for pipeline_run_ctrl; watchdog expectations follow PIPE_WATCHDOG_EN.
module tb_pipeline_run_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        pipe_en, done, halted, timeout;
  logic [2:0]  state_o;
  logic [31:0] cycle_count;
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [31:0] I_NOP  = 32'h2000_0000;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;

  pipeline_run_ctrl_if cmd_if ();

  pipeline_run_ctrl #(.WDOG_LIMIT(20)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd               (cmd_if.slave),
    .instruction_IF_ID (instr),
    .pipe_en           (pipe_en),
    .state_o           (state_o),
    .cycle_count       (cycle_count),
    .done              (done),
    .halted            (halted),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] code);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_code  = code;
    tick();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_code  = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr = I_NOP;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_code  = 2'b00;

    // 1. reset
    do_reset();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pipe_en", 32'(pipe_en), 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);

    // 2. single step
    do_cmd(2'b10);
    chk("step_state", 32'(state_o), 32'd2);
    chk("step_pipe_en", 32'(pipe_en), 32'd1);
    chk("step_ready", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    chk("step_back_state", 32'(state_o), 32'd0);
    chk("step_back_pipe_en", 32'(pipe_en), 32'd0);
    chk("step_count", cycle_count, 32'd1);
    chk("step_back_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // 3. run to HALT on the 10th enabled cycle, drain, done
    do_reset();
    do_cmd(2'b01);
    tick(9);
    instr = I_HALT;
    chk("run_state_pre_halt", 32'(state_o), 32'd1);
    chk("run_count_pre_halt", cycle_count, 32'd9);
    tick();
    chk("drain1_state", 32'(state_o), 32'd3);
    chk("drain1_pipe_en", 32'(pipe_en), 32'd1);
    chk("drain1_done", 32'(done), 32'd0);
    tick();
    chk("drain2_state", 32'(state_o), 32'd3);
    tick();
    chk("done_state", 32'(state_o), 32'd4);
    chk("done_count", cycle_count, 32'd12);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_halted", 32'(halted), 32'd1);
    chk("done_pipe_en", 32'(pipe_en), 32'd0);
    chk("done_ready", 32'(cmd_if.cmd_ready), 32'd0);
    instr = I_NOP;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_code  = 2'b01;
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("done_pulse_gone", 32'(done), 32'd0);
    chk("done_sticky_state", 32'(state_o), 32'd4);
    chk("done_count_hold", cycle_count, 32'd12);
    chk("done_timeout", 32'(timeout), 32'd0);

    // 4. pause and resume, then PAUSE together with hit
    do_reset();
    do_cmd(2'b01);
    tick(4);
    chk("pre_pause_count", cycle_count, 32'd4);
    do_cmd(2'b11);
    chk("pause_state", 32'(state_o), 32'd0);
    chk("pause_count", cycle_count, 32'd5);
    tick(3);
    chk("paused_pipe_en", 32'(pipe_en), 32'd0);
    chk("paused_count", cycle_count, 32'd5);
    do_cmd(2'b01);
    chk("resume_state", 32'(state_o), 32'd1);
    chk("resume_count", cycle_count, 32'd5);
    do_cmd(2'b10);
    chk("run_ignores_step", 32'(state_o), 32'd1);
    chk("run_count_after", cycle_count, 32'd6);
    instr = I_HALT;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_code  = 2'b11;
    chk("pause_hit_ready", 32'(cmd_if.cmd_ready), 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    instr = I_NOP;
    chk("pause_hit_state", 32'(state_o), 32'd3);

    // 5. reset during the first DRAIN cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_pipe_en", 32'(pipe_en), 32'd0);
    chk("mid_rst_count", cycle_count, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    tick();
    chk("mid_rst_no_done", 32'(done), 32'd0);
    chk("mid_rst_idle", 32'(state_o), 32'd0);

    // 6. watchdog with WDOG_LIMIT=20 and no HALT
    do_reset();
    do_cmd(2'b01);
    tick(19);
    chk("wd_pre_count", cycle_count, 32'd19);
    chk("wd_pre_state", 32'(state_o), 32'd1);
    tick();
    chk("wd_count", cycle_count, 32'd20);
`ifdef PIPE_WATCHDOG_EN
    chk("wd_state", 32'(state_o), 32'd4);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_done", 32'(done), 32'd1);
    tick(2);
    chk("wd_count_hold", cycle_count, 32'd20);
    chk("wd_timeout_sticky", 32'(timeout), 32'd1);
`else
    chk("nowd_state", 32'(state_o), 32'd1);
    chk("nowd_timeout", 32'(timeout), 32'd0);
    tick(5);
    chk("nowd_state_late", 32'(state_o), 32'd1);
    chk("nowd_count_late", cycle_count, 32'd25);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
